// File: rtl/fifo_operator_pipe.sv
// Reads one word from every enabled input FIFO, combines them with OR/AND/XOR/ADD and
// writes the result through a 2-entry credit-managed buffer. Optional counters: FIFO_OPERATOR_PIPE_STATS_EN.
module fifo_operator_pipe #(
  parameter int    WIDTH     = 4,
  parameter int    DATA_W    = 32,
  parameter string FWFT_MODE = "TRUE",
  parameter string OP        = "OR"
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          ch_en,
  input  logic [WIDTH-1:0]          r_empty,
  output logic [WIDTH-1:0]          r_req,
  input  logic [WIDTH*DATA_W-1:0]   r_data,
  input  logic                      w_full,
  output logic                      w_req,
  output logic [DATA_W-1:0]         w_data,
  output logic                      ovf,
  output logic [31:0]               word_cnt,
  output logic [31:0]               stall_cnt
);

  localparam bit FWFT   = (FWFT_MODE == "TRUE");
  localparam bit IS_AND = (OP == "AND");
  localparam bit IS_XOR = (OP == "XOR");
  localparam bit IS_ADD = (OP == "ADD");
  localparam int SUM_W  = DATA_W + $clog2(WIDTH) + 1;

  logic [1:0]        cnt;
  logic [DATA_W-1:0] obuf [2];
  logic              inflight;
  logic [WIDTH-1:0]  en_q;
  logic [WIDTH-1:0]  op_en;
  logic              ready;
  logic              rd;
  logic              pop;
  logic              push;
  logic [DATA_W-1:0] bits_acc;
  logic [SUM_W-1:0]  sum_acc;
  logic [DATA_W-1:0] result;
  logic              wrap;

  assign ready = (|ch_en) && ((ch_en & r_empty) == '0);
  assign w_req = (cnt != 2'd0) && !w_full;
  assign pop   = w_req;
  assign w_data = (cnt != 2'd0) ? obuf[0] : '0;

  // Credit test cnt + inflight - pop < 2, rearranged so it cannot underflow.
  assign rd    = !rst && ready &&
                 (({1'b0, cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
  assign r_req = rd ? ch_en : '0;

  // In FWFT mode data arrives with the read; otherwise one cycle later with the captured mask.
  assign op_en = FWFT ? ch_en : en_q;
  assign push  = FWFT ? rd : inflight;

  // NOTE: every variable gets a default before the loop, so no latch can be inferred.
  always_comb begin
    bits_acc = IS_AND ? '1 : '0;
    sum_acc  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (op_en[i]) begin
        if (IS_AND)      bits_acc = bits_acc & r_data[i*DATA_W +: DATA_W];
        else if (IS_XOR) bits_acc = bits_acc ^ r_data[i*DATA_W +: DATA_W];
        else             bits_acc = bits_acc | r_data[i*DATA_W +: DATA_W];
        sum_acc = sum_acc + SUM_W'(r_data[i*DATA_W +: DATA_W]);
      end
    end
    result = IS_ADD ? sum_acc[DATA_W-1:0] : bits_acc;
    wrap   = IS_ADD && (sum_acc[SUM_W-1:DATA_W] != '0);
  end

  // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
  // NOTE: obuf holds only two words, so it is cleared on reset like ordinary flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 2'd0;
      obuf[0]  <= '0;
      obuf[1]  <= '0;
      inflight <= 1'b0;
      en_q     <= '0;
      ovf      <= 1'b0;
    end else begin
      inflight <= FWFT ? 1'b0 : rd;
      if (rd) en_q <= ch_en;
      if (push && wrap) ovf <= 1'b1;
      case ({push, pop})
        2'b01: begin
          obuf[0] <= obuf[1];
          cnt     <= cnt - 2'd1;
        end
        2'b10: begin
          if (cnt == 2'd0) obuf[0] <= result;
          else             obuf[1] <= result;
          cnt <= cnt + 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            obuf[0] <= result;
          end else begin
            obuf[0] <= obuf[1];
            obuf[1] <= result;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_OPERATOR_PIPE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (w_req) word_cnt <= word_cnt + 32'd1;
      if ((cnt != 2'd0) && w_full) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign word_cnt  = '0;
  assign stall_cnt = '0;
`endif

endmodule
